// File: rtl/sm_debug_display.sv
// sm_debug_display
// Once per display frame, takes a 32-bit snapshot of one CPU debug register
// and scans it as 8 hex digits onto a common-anode 7-segment display.
// Ports:
//   clk, rst         single clock domain, synchronous active-high reset
//   regSel[4:0]      manual register select (0 = PC), sampled at frame end
//   autoMode         1 = step r0..r31, AUTO_FRAMES frames per register
//   hold             1 = freeze snapshot/address; scanning continues
//   regAddr[4:0]     to CPU debug address port
//   regData[31:0]    from CPU debug data port (combinational on regAddr)
//   seg[6:0]         {g,f,e,d,c,b,a}, active-low
//   anode[7:0]       digit enables, active-low, bit i = nibble i
//   dp               decimal point, active-low, lit on digit 0 when showing PC
//   curAddr[4:0]     address of the register currently displayed
module sm_debug_display #(
    parameter int SCAN_DIV    = 16,
    parameter int AUTO_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  regSel,
    input  logic        autoMode,
    input  logic        hold,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [6:0]  seg,
    output logic [7:0]  anode,
    output logic        dp,
    output logic [4:0]  curAddr
);
    localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(AUTO_FRAMES - 1);

    localparam logic [0:0] S_SAMPLE = 1'b0;
    localparam logic [0:0] S_SHOW   = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [SCAN_DIV-1:0] cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [FW-1:0]       frm_q, frm_d;
    logic [4:0]          addr_q, addr_d;
    logic [4:0]          cur_q, cur_d;
    logic [31:0]         snap_q, snap_d;
    logic [6:0]          seg_q, seg_d;
    logic [7:0]          an_q, an_d;
    logic                dp_q, dp_d;

    logic tick, frame_end;
    logic [3:0] nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick      = &cnt_q;
    assign frame_end = tick && (idx_q == 3'd7);
    assign nibble    = snap_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + SCAN_DIV'(1);
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
        frm_d   = frm_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        snap_d  = snap_q;
        // Display registers follow the current index/snapshot one cycle later.
        an_d    = ~(8'b1 << idx_q);
        seg_d   = hex7(nibble);
        dp_d    = ~((idx_q == 3'd0) && (cur_q == 5'd0));

        case (state_q)
            S_SAMPLE: begin
                // regAddr was loaded last cycle; the CPU port is combinational,
                // so regData already belongs to it.
                snap_d  = regData;
                cur_d   = addr_q;
                state_d = S_SHOW;
            end
            default: begin
                if (frame_end && !hold) begin
                    state_d = S_SAMPLE;
                    if (autoMode) begin
                        if (frm_q == FRM_LAST) begin
                            frm_d  = '0;
                            addr_d = cur_q + 5'd1;
                        end else begin
                            frm_d  = frm_q + FW'(1);
                            addr_d = cur_q;   // resample so the live value updates
                        end
                    end else begin
                        frm_d  = '0;
                        addr_d = regSel;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SAMPLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            frm_q   <= '0;
            addr_q  <= 5'd0;
            cur_q   <= 5'd0;
            snap_q  <= 32'd0;
            seg_q   <= 7'b1000000;
            an_q    <= 8'hFE;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            addr_q  <= addr_d;
            cur_q   <= cur_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign regAddr = addr_q;
    assign curAddr = cur_q;
    assign seg     = seg_q;
    assign anode   = an_q;
    assign dp      = dp_q;
endmodule

// File: tb/tb_sm_debug_display.sv
// Bench for sm_debug_display with SCAN_DIV=2, AUTO_FRAMES=2 (4-clock dwell,
// 32-clock frame). A CPU register file array drives regData from regAddr.
// The reference model works in terms of clocks since reset: dwell position
// and digit come from arithmetic on that count, a frame ends every 32 clocks.
module tb_sm_debug_display;
    localparam int SD = 2;
    localparam int AF = 2;
    localparam int DWELL = 1 << SD;
    localparam int FRAME = 8 * DWELL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  regSel = 5'd0;
    logic        autoMode = 1'b0;
    logic        hold = 1'b0;
    logic [4:0]  regAddr, curAddr;
    logic [31:0] regData;
    logic [6:0]  seg;
    logic [7:0]  anode;
    logic        dp;

    logic [31:0] rf [32];
    assign regData = rf[regAddr];

    sm_debug_display #(.SCAN_DIV(SD), .AUTO_FRAMES(AF)) dut (
        .clk(clk), .rst(rst), .regSel(regSel), .autoMode(autoMode),
        .hold(hold), .regAddr(regAddr), .regData(regData), .seg(seg),
        .anode(anode), .dp(dp), .curAddr(curAddr)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model
    int          m_t, m_addr, m_cur, m_frm, m_idx;
    logic [31:0] m_snap;
    bit          m_sample, armed;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_addr = 0; m_cur = 0; m_frm = 0; m_snap = 32'd0;
            m_sample = 1'b1; armed = 1'b1;
            e_an = 8'hFE; e_seg = hex_tab[0]; e_dp = 1'b0;
        end else begin
            m_idx = (m_t / DWELL) % 8;
            e_an  = ~(8'd1 << m_idx);
            e_seg = hex_tab[m_snap[m_idx*4 +: 4]];
            e_dp  = !(m_idx == 0 && m_cur == 0);
            if (m_sample) begin
                m_snap = rf[m_addr];
                m_cur = m_addr;
                m_sample = 1'b0;
            end else if ((m_t % FRAME) == FRAME - 1 && !hold) begin
                if (!autoMode) begin
                    m_frm = 0;
                    m_addr = regSel;
                end else if (m_frm == AF - 1) begin
                    m_frm = 0;
                    m_addr = (m_cur + 1) % 32;
                end else begin
                    m_frm = m_frm + 1;
                    m_addr = m_cur;
                end
                m_sample = 1'b1;
            end
            m_t = m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("regAddr", regAddr, m_addr);
            chk("curAddr", curAddr, m_cur);
            chk("anode", anode, e_an);
            chk("seg", seg, e_seg);
            chk("dp", dp, e_dp);
        end
    end

    task automatic goto(input int t);
        while (m_t < t) @(negedge clk);
    endtask

    int seq [7] = '{30, 30, 31, 31, 0, 0, 1};

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'h00000040;
        rf[5] = 32'h1234ABCD;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_regAddr", regAddr, 0);
        chk("rst_anode", anode, 8'hFE);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_dp", dp, 0);
        goto(1);
        chk("pc_cur", curAddr, 0);
        chk("pc_dp", dp, 0);
        goto(6);
        chk("pc_d1_anode", anode, 8'hFD);
        chk("pc_d1_seg", seg, 7'b0011001);

        regSel = 5'd5;
        goto(32);
        chk("sel5_regAddr", regAddr, 5);
        chk("sel5_cur_old", curAddr, 0);
        goto(34);
        chk("sel5_cur", curAddr, 5);
        chk("sel5_d0_seg", seg, 7'b0100001);
        chk("sel5_dp", dp, 1);

        goto(40);
        rf[5] = 32'hFFFFFFFF;
        goto(46);
        chk("midframe_anode", anode, 8'hF7);
        chk("midframe_seg", seg, 7'b0001000);
        goto(66);
        chk("newframe_seg", seg, 7'b0001110);

        regSel = 5'd30;
        goto(98);
        autoMode = 1'b1;
        for (int k = 0; k < 7; k++) begin
            goto(98 + FRAME * k);
            chk("auto_seq", curAddr, seq[k]);
        end

        autoMode = 1'b0;
        regSel = 5'd7;
        goto(300);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            goto(330 + FRAME * k);
            chk("hold_cur", curAddr, 1);
            chk("hold_regAddr", regAddr, 1);
        end
        goto(400);
        hold = 1'b0;
        goto(418);
        chk("release_cur", curAddr, 7);

        goto(438);
        chk("digit5_anode", anode, 8'hDF);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_anode", anode, 8'hFE);
        chk("midrst_seg", seg, 7'b1000000);
        chk("midrst_cur", curAddr, 0);
        rst = 1'b0;
        goto(34);
        chk("postrst_cur", curAddr, 7);

        for (int it = 0; it < 60; it++) begin
            int nxt;
            nxt = m_t + int'($urandom_range(5, 60));
            goto(nxt);
            case ($urandom_range(0, 4))
                0: regSel = 5'($urandom);
                1: autoMode = ~autoMode;
                2: hold = ($urandom_range(0, 3) == 0);
                3: rf[$urandom_range(0, 31)] = $urandom;
                default: if ($urandom_range(0, 3) == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
            endcase
        end
        hold = 1'b0;
        goto(m_t + 2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
